// File: rtl/rv32i_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing XOR checksum byte).
package rv32i_imem_loader_pkg;

  localparam int unsigned INST_W = 32;

  // Loader state encodings (3 bits)
  typedef enum logic [2:0] {
    LDR_LEN   = 3'd0,
    LDR_DATA  = 3'd1,
    LDR_WRITE = 3'd2,
    LDR_CKSUM = 3'd3,
    LDR_DONE  = 3'd4,
    LDR_ERR   = 3'd5
  } ldr_state_e;

  // True while a frame is in flight
  function automatic logic is_busy(input ldr_state_e s);
    return (s == LDR_LEN) || (s == LDR_DATA) || (s == LDR_WRITE) || (s == LDR_CKSUM);
  endfunction

endpackage

// File: rtl/rv32i_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface rv32i_imem_loader_if #(
  parameter int unsigned IMEM_AW = 10
);
  import rv32i_imem_loader_pkg::*;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [INST_W-1:0] imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/rv32i_loader_timer.sv
// Inter-byte idle timer: clearable, enabled down-counter holding the remaining
// idle budget; expired_c fires on the idle cycle that exhausts it.
module rv32i_loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  // Reload on clear, count down on idle cycles, park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expired_c = en && (cnt == '0);
endmodule

// File: rtl/rv32i_imem_loader.sv
// Program-image loader: byte stream -> LE 32-bit words -> instruction memory,
// holding the core in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte, CKSUM state).
module rv32i_imem_loader
  import rv32i_imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_AW        = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  rv32i_imem_loader_if.master bus,
  input  logic                start,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int unsigned IW = IMEM_AW + 1;
  localparam logic [32:0] MAX_WORDS = 33'(1) << IMEM_AW;

  ldr_state_e state, state_next;
  logic [31:0]        len, len_next, len_full;
  logic [INST_W-1:0]  word, word_next, word_full;
  logic [IW-1:0]      idx, idx_next;
  logic [1:0]         byte_cnt, byte_cnt_next;
  logic               rx_ready_q, rx_ready_next;
  logic               we_q, we_next;
  logic [IMEM_AW-1:0] waddr_q, waddr_next;
  logic [INST_W-1:0]  wdata_q, wdata_next;
  logic               cpu_rst_next, busy_next, done_next, err_next;
  logic               accept_c, counting_c, timer_exp_c;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum, csum_next;
`endif

  assign accept_c   = bus.rx_valid & rx_ready_q;
  assign counting_c = ((state == LDR_LEN) && (byte_cnt != 2'd0)) ||
                      (state == LDR_DATA) || (state == LDR_CKSUM);

  rv32i_loader_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept_c | ~counting_c),
    .en        (counting_c & ~accept_c),
    .expired_c (timer_exp_c)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LDR_LEN;
      len        <= '0;
      word       <= '0;
      idx        <= '0;
      byte_cnt   <= '0;
      rx_ready_q <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_next;
      len        <= len_next;
      word       <= word_next;
      idx        <= idx_next;
      byte_cnt   <= byte_cnt_next;
      rx_ready_q <= rx_ready_next;
      we_q       <= we_next;
      waddr_q    <= waddr_next;
      wdata_q    <= wdata_next;
      cpu_rst    <= cpu_rst_next;
      busy       <= busy_next;
      done       <= done_next;
      err        <= err_next;
`ifdef LOADER_CHECKSUM_EN
      csum       <= csum_next;
`endif
    end
  end

  // Next-state, assembly and output decode
  always_comb begin
    state_next    = state;
    len_next      = len;
    word_next     = word;
    idx_next      = idx;
    byte_cnt_next = byte_cnt;
    waddr_next    = waddr_q;
    wdata_next    = wdata_q;
    len_full      = {bus.rx_data, len[31:8]};
    word_full     = {bus.rx_data, word[31:8]};
`ifdef LOADER_CHECKSUM_EN
    csum_next     = csum;
`endif

    case (state)
      LDR_LEN: begin
        if (accept_c) begin
          len_next      = len_full;
          byte_cnt_next = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (len_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_next = LDR_CKSUM;
`else
              state_next = LDR_DONE;
`endif
            end else if ({1'b0, len_full} > MAX_WORDS) begin
              state_next = LDR_ERR;
            end else begin
              state_next = LDR_DATA;
            end
          end
        end else if (timer_exp_c) begin
          state_next = LDR_ERR;
        end
      end

      LDR_DATA: begin
        if (accept_c) begin
          word_next     = word_full;
          byte_cnt_next = byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_next     = csum ^ bus.rx_data;
`endif
          if (byte_cnt == 2'd3) begin
            state_next = LDR_WRITE;
            waddr_next = idx[IMEM_AW-1:0];
            wdata_next = word_full;
          end
        end else if (timer_exp_c) begin
          state_next = LDR_ERR;
        end
      end

      LDR_WRITE: begin
        idx_next = idx + IW'(1);
        if (32'(idx) == (len - 32'd1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = LDR_CKSUM;
`else
          state_next = LDR_DONE;
`endif
        end else begin
          state_next = LDR_DATA;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      LDR_CKSUM: begin
        if (accept_c) begin
          state_next = (bus.rx_data == csum) ? LDR_DONE : LDR_ERR;
        end else if (timer_exp_c) begin
          state_next = LDR_ERR;
        end
      end
`endif

      // Timer is held cleared here because neither state counts
      LDR_DONE, LDR_ERR: begin
        if (start) begin
          state_next    = LDR_LEN;
          len_next      = '0;
          word_next     = '0;
          idx_next      = '0;
          byte_cnt_next = '0;
          waddr_next    = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_next     = '0;
`endif
        end
      end

      default: state_next = LDR_ERR;
    endcase

    rx_ready_next = (state_next == LDR_LEN) || (state_next == LDR_DATA) ||
                    (state_next == LDR_CKSUM);
    we_next       = (state_next == LDR_WRITE);
    cpu_rst_next  = (state_next != LDR_DONE);
    busy_next     = is_busy(state_next);
    done_next     = (state_next == LDR_DONE);
    err_next      = (state_next == LDR_ERR);
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Directed bench for rv32i_imem_loader (IMEM_AW=4, TIMEOUT_CYCLES=16).
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_rv32i_imem_loader;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_rst, busy, done, err;
  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  rv32i_imem_loader_if #(.IMEM_AW(AW)) bus();

  rv32i_imem_loader #(.IMEM_AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .start   (start),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Record every memory write cycle
  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) begin
      log_addr.push_back(bus.imem_waddr);
      log_data.push_back(bus.imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus.rx_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL rx_ready_wait: rx_ready=%b after %0d cycles, required 1", bus.rx_ready, waited);
    end else begin
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({bus.rx_ready, bus.imem_we, cpu_rst, busy, done, err} !== 6'b101100) begin
      miscompares++;
      $display("FAIL reset_flags: {rdy,we,cpu_rst,busy,done,err}=%b required 101100",
               {bus.rx_ready, bus.imem_we, cpu_rst, busy, done, err});
    end
    vectors++;
    if (bus.imem_waddr !== 4'h0 || bus.imem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus: waddr=%h wdata=%h required 0/0", bus.imem_waddr, bus.imem_wdata);
    end
  endtask

  task automatic test_two_words();
    log_addr.delete(); log_data.delete();
    send_word(32'd2);
    send_word(32'h00500093);
    vectors++;
    if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 4'd0 || bus.imem_wdata !== 32'h00500093 || bus.rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL write0: we=%b addr=%h data=%h rdy=%b required 1/0/00500093/0",
               bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.rx_ready);
    end
    send_word(32'h00100113);
    vectors++;
    if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 4'd1 || bus.imem_wdata !== 32'h00100113 || cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL write1: we=%b addr=%h data=%h cpu_rst=%b required 1/1/00100113/1",
               bus.imem_we, bus.imem_waddr, bus.imem_wdata, cpu_rst);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hC1);
`else
    @(posedge clk); #1;
`endif
    vectors++;
    if ({done, cpu_rst, busy, err, bus.imem_we} !== 5'b10000) begin
      miscompares++;
      $display("FAIL two_words_done: {done,cpu_rst,busy,err,we}=%b required 10000",
               {done, cpu_rst, busy, err, bus.imem_we});
    end
    vectors++;
    if (log_addr.size() != 2) begin
      miscompares++;
      $display("FAIL two_words_count: writes=%0d required 2", log_addr.size());
    end
  endtask

  task automatic test_zero_len();
    pulse_start();
    vectors++;
    if (bus.imem_waddr !== 4'd0 || done !== 1'b0 || busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart: waddr=%h done=%b busy=%b rdy=%b required 0/0/1/1",
               bus.imem_waddr, done, busy, bus.rx_ready);
    end
    log_addr.delete(); log_data.delete();
    send_word(32'd0);
`ifdef LOADER_CHECKSUM_EN
    vectors++;
    if (done !== 1'b0 || bus.rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_cksum_wait: done=%b rdy=%b required 0/1", done, bus.rx_ready);
    end
    send_byte(8'h00);
`endif
    vectors++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || log_addr.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len: done=%b cpu_rst=%b writes=%0d required 1/0/0", done, cpu_rst, log_addr.size());
    end
  endtask

  task automatic test_too_long();
    pulse_start();
    log_addr.delete(); log_data.delete();
    send_word(32'd17);
    vectors++;
    if ({err, cpu_rst, done, busy, bus.rx_ready} !== 5'b11000 || log_addr.size() != 0) begin
      miscompares++;
      $display("FAIL too_long: {err,cpu_rst,done,busy,rdy}=%b writes=%0d required 11000/0",
               {err, cpu_rst, done, busy, bus.rx_ready}, log_addr.size());
    end
    pulse_start();
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: err=%b busy=%b rdy=%b required 0/1/1", err, busy, bus.rx_ready);
    end
  endtask

  task automatic test_timeout();
    log_addr.delete(); log_data.delete();
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_start();
    repeat (TO - 2) @(posedge clk);
    #1;
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: err=%b busy=%b required 0/1", err, busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || log_addr.size() != 0) begin
      miscompares++;
      $display("FAIL timeout: err=%b cpu_rst=%b writes=%0d required 1/1/0", err, cpu_rst, log_addr.size());
    end
  endtask

  task automatic test_full_capacity();
    logic [7:0] cs = 8'h00;
    logic [31:0] w;
    pulse_start();
    log_addr.delete(); log_data.delete();
    send_word(32'd16);
    for (int i = 0; i < 16; i++) begin
      w = 32'hA5000000 | 32'(i * 3);
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(w);
    end
    vectors++;
    if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 4'd15 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL full_last: we=%b addr=%h done=%b required 1/f/0", bus.imem_we, bus.imem_waddr, done);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    @(posedge clk); #1;
`endif
    vectors++;
    if (done !== 1'b1 || err !== 1'b0 || log_addr.size() != 16) begin
      miscompares++;
      $display("FAIL full_done: done=%b err=%b writes=%0d required 1/0/16", done, err, log_addr.size());
    end
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      vectors++;
      if (log_addr[i] !== 4'(i) || log_data[i] !== (32'hA5000000 | 32'(i * 3))) begin
        miscompares++;
        $display("FAIL full_entry%0d: addr=%h data=%h required %h/%h", i, log_addr[i], log_data[i],
                 4'(i), 32'hA5000000 | 32'(i * 3));
      end
    end
  endtask

  task automatic test_rst_mid_word();
    pulse_start();
    log_addr.delete(); log_data.delete();
    send_word(32'd2);
    send_word(32'h12345678);
    send_byte(8'h9A);
    send_byte(8'hBC);
    rst = 1'b1;
    #2;
    vectors++;
    if ({bus.rx_ready, bus.imem_we, cpu_rst, busy, done, err} !== 6'b101100 ||
        bus.imem_waddr !== 4'h0 || bus.imem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL async_rst: flags=%b waddr=%h wdata=%h required 101100/0/0",
               {bus.rx_ready, bus.imem_we, cpu_rst, busy, done, err}, bus.imem_waddr, bus.imem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (log_addr.size() != 1) begin
      miscompares++;
      $display("FAIL partial_discard: writes=%0d required 1", log_addr.size());
    end
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    vectors++;
    if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 4'd0 || bus.imem_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL fresh_write: we=%b addr=%h data=%h required 1/0/deadbeef",
               bus.imem_we, bus.imem_waddr, bus.imem_wdata);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h22);
`else
    @(posedge clk); #1;
`endif
    vectors++;
    if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL fresh_done: done=%b cpu_rst=%b required 1/0", done, cpu_rst);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_word(32'd1);
    send_word(32'h11223344);
    send_byte(8'h44);
    vectors++;
    if (done !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL cksum_good: done=%b err=%b required 1/0", done, err);
    end
    pulse_start();
    send_word(32'd1);
    send_word(32'h11223344);
    send_byte(8'h45);
    vectors++;
    if (done !== 1'b0 || err !== 1'b1 || cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL cksum_bad: done=%b err=%b cpu_rst=%b required 0/1/1", done, err, cpu_rst);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_too_long();
    test_timeout();
    test_full_capacity();
    test_rst_mid_word();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
